// File: rtl/dm_pkg.sv
// Debug-module DMI types shared between the DTM-side controller and the DM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm;

  // DMI operation field as shifted in through the dmi register
  typedef enum logic [1:0] {
    DTMNop   = 2'd0,
    DTMRead  = 2'd1,
    DTMWrite = 2'd2
  } dtm_op_e;

  // Request payload to the DM: addr is most significant, data least
  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  // Response payload from the DM; resp != 0 signals an operation failure
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // dtmcs.dmistat codes
  localparam logic [1:0] DMINoError       = 2'd0;
  localparam logic [1:0] DMIReservedError = 2'd1;
  localparam logic [1:0] DMIOPFailed      = 2'd2;
  localparam logic [1:0] DMIBusy          = 2'd3;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI transaction controller: turns dmi Update-DR pulses into one outstanding DM request.
// Latency: update -> req valid next cycle; response -> idle/data/status next cycle.
// Backpressure: request held stable until ready; a response is always accepted while waiting.
module dmi_access_ctrl
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        update_i,
  input  logic        capture_i,
  input  logic        dmireset_i,
  input  dmi_req_t    dmi_access_i,
  output logic [40:0] dmi_capture_o,
  output logic [1:0]  dmi_status_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output dmi_req_t    dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  dmi_resp_t   dmi_resp_i
);

  // A zero timeout disables the timer; keep the counter at least one bit wide
  localparam int unsigned TimerW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [TimerW-1:0] TimerLimit = TimerW'(TimeoutCycles);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitResp,
    StDrain
  } state_e;

  state_e            state_q;
  dmi_req_t          req_q;
  logic [31:0]       data_q;
  logic [1:0]        error_q;
  logic [TimerW-1:0] timer_q;
  logic              req_valid_q;
  logic              resp_ready_q;
  logic [1:0]        capture_op;

  // Transaction FSM, sticky error and registered handshake outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_q        <= '0;
      data_q       <= '0;
      error_q      <= DMINoError;
      timer_q      <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      // Clear has lowest priority: any error raised below in this cycle overrides it
      if (dmireset_i) begin
        error_q <= DMINoError;
      end
      // Host touched the register mid-transaction; only the first error is kept
      if ((update_i || capture_i) && (state_q != StIdle) && (error_q == DMINoError)) begin
        error_q <= DMIBusy;
      end

      case (state_q)
        StIdle: begin
          if (update_i && (error_q == DMINoError) &&
              ((dmi_access_i.op == DTMRead) || (dmi_access_i.op == DTMWrite))) begin
            req_q       <= dmi_access_i;
            req_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end

        StIssue: begin
          if (dmi_req_ready_i) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            timer_q      <= '0;
            state_q      <= StWaitResp;
          end
        end

        StWaitResp: begin
          if (dmi_resp_valid_i) begin
            // Reads return DM data; writes leave the written word visible at capture
            if (req_q.op == DTMRead) begin
              data_q <= dmi_resp_i.data;
            end else begin
              data_q <= req_q.data;
            end
            // A failing response outranks a busy raised in the same cycle
            if (dmi_resp_i.resp != 2'd0) begin
              error_q <= DMIOPFailed;
            end
            resp_ready_q <= 1'b0;
            state_q      <= StIdle;
          end else if ((TimeoutCycles != 0) && (timer_q == TimerLimit)) begin
            // DM looks hung: flag failure and swallow whatever response arrives later
            error_q <= DMIOPFailed;
            state_q <= StDrain;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StDrain: begin
          if (dmi_resp_valid_i) begin
            resp_ready_q <= 1'b0;
            state_q      <= StIdle;
          end
        end

        default: begin
          state_q      <= StIdle;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Op field reported at Capture-DR, derived only from registered state
  always_comb begin
    capture_op = DMINoError;
    if (error_q != DMINoError) begin
      capture_op = error_q;
    end else if (state_q != StIdle) begin
      capture_op = DMIBusy;
    end
  end

  assign dmi_capture_o    = {req_q.addr, data_q, capture_op};
  assign dmi_status_o     = error_q;
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_req_o        = req_q;
  assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Self-checking bench for dmi_access_ctrl: directed scenarios then randomized transactions.
// Expected values come from a transaction-level model of the dmistat/capture rules.
// All stimulus and sampling happen 1 time unit after the rising clock edge.
module tb_dmi_access_ctrl;
  import dm::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        update_i;
  logic        capture_i;
  logic        dmireset_i;
  dmi_req_t    dmi_access_i;
  logic [40:0] dmi_capture_o;
  logic [1:0]  dmi_status_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  dmi_req_t    dmi_req_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  dmi_resp_t   dmi_resp_i;

  dmi_access_ctrl #(.TimeoutCycles(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .update_i         (update_i),
    .capture_i        (capture_i),
    .dmireset_i       (dmireset_i),
    .dmi_access_i     (dmi_access_i),
    .dmi_capture_o    (dmi_capture_o),
    .dmi_status_o     (dmi_status_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_i       (dmi_resp_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sticky error plus what the last completed transaction left behind
  logic [1:0]  m_err;
  logic [6:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [40:0] cap_idle();
    return {m_addr, m_data, m_err};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".status"}, 64'(dmi_status_o), 64'(m_err));
    chk({tag, ".capture"}, 64'(dmi_capture_o), 64'(cap_idle()));
    chk({tag, ".valid"}, 64'(dmi_req_valid_o), 64'd0);
    chk({tag, ".rready"}, 64'(dmi_resp_ready_o), 64'd0);
  endtask

  task automatic raise(input logic [1:0] code);
    if (code == DMIBusy) begin
      if (m_err == DMINoError) m_err = DMIBusy;
    end else begin
      m_err = code;
    end
  endtask

  task automatic do_dmireset();
    dmireset_i = 1'b1;
    tick();
    dmireset_i = 1'b0;
    m_err = DMINoError;
    chk("dmireset.status", 64'(dmi_status_o), 64'd0);
  endtask

  // One full host transaction; to=1 lets the DM stay silent until the timeout fires
  task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                         input int ready_dly, input int resp_dly, input logic [1:0] resp_code,
                         input logic [31:0] resp_data, input bit busy_upd, input bit cap_on_resp,
                         input bit to);
    logic [40:0] exp_req;
    bit accepted;
    accepted = ((op == 2'd1) || (op == 2'd2)) && (m_err == DMINoError);
    dmi_access_i = '{addr: addr, op: dtm_op_e'(op), data: data};
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    if (!accepted) begin
      chk_idle("reject");
      return;
    end
    exp_req = {addr, op, data};
    m_addr = addr;
    chk("issue.valid", 64'(dmi_req_valid_o), 64'd1);
    chk("issue.payload", 64'(dmi_req_o), 64'(exp_req));
    for (int i = 0; i < ready_dly; i++) begin
      tick();
      chk("hold.valid", 64'(dmi_req_valid_o), 64'd1);
      chk("hold.payload", 64'(dmi_req_o), 64'(exp_req));
      chk("hold.capture", 64'(dmi_capture_o),
          64'({addr, m_data, (m_err != 2'd0) ? m_err : DMIBusy}));
    end
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    chk("wait.valid", 64'(dmi_req_valid_o), 64'd0);
    chk("wait.rready", 64'(dmi_resp_ready_o), 64'd1);
    if (to) begin
      repeat (4) tick();
      chk("to.pre_status", 64'(dmi_status_o), 64'(m_err));
      tick();
      raise(DMIOPFailed);
      chk("to.status", 64'(dmi_status_o), 64'(m_err));
      chk("drain.rready", 64'(dmi_resp_ready_o), 64'd1);
      dmi_resp_valid_i = 1'b1;
      dmi_resp_i = '{data: resp_data, resp: 2'd0};
      tick();
      dmi_resp_valid_i = 1'b0;
      chk_idle("drained");
      return;
    end
    for (int j = 0; j < resp_dly; j++) begin
      if (busy_upd && j == 0) begin
        dmi_access_i = '{addr: 7'(~addr), op: dtm_op_e'($urandom_range(0, 3)), data: ~data};
        update_i = 1'b1;
      end
      tick();
      if (busy_upd && j == 0) begin
        update_i = 1'b0;
        raise(DMIBusy);
        chk("busy.status", 64'(dmi_status_o), 64'(m_err));
        chk("busy.no_req", 64'(dmi_req_valid_o), 64'd0);
        chk("busy.payload", 64'(dmi_req_o), 64'(exp_req));
      end
    end
    dmi_resp_valid_i = 1'b1;
    dmi_resp_i = '{data: resp_data, resp: resp_code};
    capture_i = cap_on_resp;
    tick();
    dmi_resp_valid_i = 1'b0;
    capture_i = 1'b0;
    if (cap_on_resp) raise(DMIBusy);
    if (resp_code != 2'd0) raise(DMIOPFailed);
    m_data = (op == 2'd1) ? resp_data : data;
    chk_idle("done");
  endtask

  initial begin
    rst_i = 1'b1;
    update_i = 1'b0;
    capture_i = 1'b0;
    dmireset_i = 1'b0;
    dmi_access_i = '0;
    dmi_req_ready_i = 1'b0;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i = '0;
    m_err = 2'd0;
    m_addr = 7'd0;
    m_data = 32'd0;
    repeat (2) tick();
    chk_idle("reset");
    chk("reset.payload", 64'(dmi_req_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Read 0x11, DM ready at once, response two cycles later
    run_txn(2'd1, 7'h11, 32'h0, 0, 2, 2'd0, 32'hDEADBEEF, 0, 0, 0);
    // Write 0x10 with ready held low for five cycles
    run_txn(2'd2, 7'h10, 32'h1, 5, 0, 2'd0, 32'hCAFE0000, 0, 0, 0);
    // Nop and op=3 start nothing
    run_txn(2'd0, 7'h22, 32'h5, 0, 0, 2'd0, 32'h0, 0, 0, 0);
    run_txn(2'd3, 7'h23, 32'h6, 0, 0, 2'd0, 32'h0, 0, 0, 0);
    // Busy during WaitResp, later update ignored, cleared by dmireset
    run_txn(2'd1, 7'h05, 32'h0, 1, 2, 2'd0, 32'h12345678, 1, 0, 0);
    run_txn(2'd1, 7'h06, 32'h0, 0, 0, 2'd0, 32'h0, 0, 0, 0);
    do_dmireset();
    run_txn(2'd1, 7'h06, 32'h0, 0, 0, 2'd0, 32'hA5A5A5A5, 0, 0, 0);
    // Failed response with a capture in the same cycle
    run_txn(2'd1, 7'h07, 32'h0, 0, 1, 2'd2, 32'h77777777, 0, 1, 0);
    do_dmireset();
    // Timeout with a late, discarded response
    run_txn(2'd1, 7'h08, 32'h0, 0, 0, 2'd0, 32'hBADBAD00, 0, 0, 1);
    do_dmireset();

    // Reset while the request is being offered
    dmi_access_i = '{addr: 7'h33, op: DTMWrite, data: 32'h99};
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    chk("rst.pre_valid", 64'(dmi_req_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    m_err = 2'd0;
    m_addr = 7'd0;
    m_data = 32'd0;
    chk_idle("rst.async");
    chk("rst.payload", 64'(dmi_req_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    run_txn(2'd2, 7'h34, 32'h55, 0, 0, 2'd0, 32'h0, 0, 0, 0);

    // Randomized transactions
    for (int k = 0; k < 60; k++) begin
      run_txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0) ? 2'd2 : 2'd0, $urandom,
              $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) do_dmireset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
